// File: rtl/perf_counter_ctrl_pkg.sv
// Shared core defines for the performance counter block:
// datapath width, register offsets, status bits and FSM encoding.
package perf_counter_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [31:0] OFF_CYCLE = 32'h00;
  localparam logic [31:0] OFF_INSTR = 32'h04;
  localparam logic [31:0] OFF_CLEAR = 32'h08;
  localparam logic [31:0] OFF_SNAP  = 32'h0C;
  localparam logic [31:0] OFF_SCYC  = 32'h10;
  localparam logic [31:0] OFF_SINS  = 32'h14;
  localparam logic [31:0] OFF_STAT  = 32'h18;

  localparam int ST_OVF  = 0;
  localparam int ST_SNAP = 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/perf_counter_ctrl_retire_counter.sv
// Retired-instruction counter with wrap detect and
// a sticky overflow flag.
module retire_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [XLEN-1:0] count,
  output logic            ovf
);

  // count retirements; clear beats a same-cycle retire
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      count <= count + 1'b1;
      if (&count) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance counter MMIO block: decode, clear FSM,
// snapshot registers and registered read mux.
module perf_counter_ctrl
  import perf_counter_ctrl_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] cycle_cnt,
  output logic            counter_rst,
  input  logic            inst_retire,
  input  logic [31:0]     mmio_addr,
  input  logic            mmio_wen,
  input  logic            mmio_ren,
  output logic [XLEN-1:0] mmio_rdata
);

  clr_state_e      state, state_n;
  logic [31:0]     off;
  logic            wr_clr, wr_snap, clr_st;
  logic [XLEN-1:0] instr_cnt;
  logic            instr_ovf;
  logic [XLEN-1:0] snap_cyc, snap_ins;
  logic            snap_valid;
  logic [XLEN-1:0] rd_mux;

  assign off     = mmio_addr - BASE_ADDR;
  assign wr_clr  = mmio_wen && (off == OFF_CLEAR);
  assign wr_snap = mmio_wen && (off == OFF_SNAP);
  assign clr_st  = (state == S_CLEAR);

  assign counter_rst = rst || clr_st;

  retire_counter #(
    .XLEN(XLEN)
  ) u_retire (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_st),
    .inc  (inst_retire),
    .count(instr_cnt),
    .ovf  (instr_ovf)
  );

  // clear FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // clear FSM next state: a clear write (re)arms CLEAR
  always_comb begin
    state_n = S_IDLE;
    unique case (state)
      S_IDLE:  if (wr_clr) state_n = S_CLEAR;
      S_CLEAR: if (wr_clr) state_n = S_CLEAR;
    endcase
  end

  // snapshot capture; clear keeps values but drops valid
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cyc   <= '0;
      snap_ins   <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (wr_snap) begin
        snap_cyc <= cycle_cnt;
        snap_ins <= instr_cnt;
      end
      if (clr_st)       snap_valid <= 1'b0;
      else if (wr_snap) snap_valid <= 1'b1;
    end
  end

  // read mux over the current (pre-write) state
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CYCLE: rd_mux = cycle_cnt;
      OFF_INSTR: rd_mux = instr_cnt;
      OFF_SCYC:  rd_mux = snap_cyc;
      OFF_SINS:  rd_mux = snap_ins;
      OFF_STAT: begin
        rd_mux[ST_OVF]  = instr_ovf;
        rd_mux[ST_SNAP] = snap_valid;
      end
      default:   rd_mux = '0;
    endcase
  end

  // registered read data, zero when idle or in reset
  always_ff @(posedge clk) begin
    if (rst)           mmio_rdata <= '0;
    else if (mmio_ren) mmio_rdata <= rd_mux;
    else               mmio_rdata <= '0;
  end

endmodule
